pa_core_exu_div: RTL and testbench

PA_CORE_EXU_DIV -- requirements
Module: pa_core_exu_div

---
 rtl/pa_core_exu_div_pkg.sv | 11 +
 rtl/pa_core_exu_div_step.sv | 19 +
 rtl/pa_core_exu_div.sv | 120 ++++++++++++
 tb/tb_pa_core_exu_div.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pa_core_exu_div_pkg.sv
// pa_core_exu_div_pkg: shared constants and FSM encoding for the iterative divider.
package pa_core_exu_div_pkg;
    localparam int PA_DATA_BUS_WIDTH = 32;
    localparam int DIV_ITER          = 32;
    localparam int DIV_CNT_W         = 6;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/pa_core_exu_div_step.sv
// pa_core_exu_div_step: one radix-2 restoring step (shift in dividend bit, trial subtract, select).
module pa_core_exu_div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic         dvd_msb_i,
    input  logic [W-1:0] dvs_i,
    output logic [W:0]   rem_o,
    output logic         q_bit_o
);
    logic [W+1:0] shifted;
    logic [W+1:0] diff;
    always_comb begin
        shifted = {rem_i, dvd_msb_i};
        diff    = shifted - {2'b00, dvs_i};
        q_bit_o = ~diff[W+1];
        rem_o   = q_bit_o ? diff[W:0] : shifted[W:0];
    end
endmodule

// File: rtl/pa_core_exu_div.sv
// pa_core_exu_div: multi-cycle signed/unsigned divider, fixed 33-cycle latency,
// with one-cycle shortcuts for divide-by-zero and signed overflow.
module pa_core_exu_div
    import pa_core_exu_div_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = PA_DATA_BUS_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic                      kill_i,
    input  logic [DATA_BUS_WIDTH-1:0] data1_i,
    input  logic [DATA_BUS_WIDTH-1:0] data2_i,
    input  logic                      sign_i,
    input  logic                      rem_i,
    output logic                      busy_o,
    output logic                      valid_o,
    output logic [DATA_BUS_WIDTH-1:0] data_o
);
    localparam int W = DATA_BUS_WIDTH;
    localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(DIV_ITER - 1);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]           rem_q, rem_d;
    logic [W-1:0]         quo_q, quo_d;
    logic [W-1:0]         dvs_q, dvs_d;
    logic [W-1:0]         data_q, data_d;
    logic                 qsign_q, qsign_d;
    logic                 rsign_q, rsign_d;
    logic                 remsel_q, remsel_d;

    logic [W:0]   step_rem;
    logic         step_q;
    logic [W-1:0] dvd_mag, dvs_mag;
    logic         div_zero, sovf;

    pa_core_exu_div_step #(.W(W)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (quo_q[W-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    assign dvd_mag  = (sign_i && data1_i[W-1]) ? -data1_i : data1_i;
    assign dvs_mag  = (sign_i && data2_i[W-1]) ? -data2_i : data2_i;
    assign div_zero = data2_i == '0;
    assign sovf     = sign_i && data1_i == {1'b1, {(W-1){1'b0}}} && &data2_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        remsel_d = remsel_q;
        data_d   = '0;
        case (state_q)
            DIV_IDLE: if (start_i) begin
                // The dividend magnitude sits in the quotient register and shifts out MSB-first.
                quo_d    = dvd_mag;
                dvs_d    = dvs_mag;
                rem_d    = '0;
                cnt_d    = '0;
                qsign_d  = sign_i & (data1_i[W-1] ^ data2_i[W-1]);
                rsign_d  = sign_i & data1_i[W-1];
                remsel_d = rem_i;
                state_d  = (div_zero || sovf) ? DIV_DONE : DIV_CALC;
                data_d   = div_zero ? (rem_i ? data1_i : '1) :
                           sovf     ? (rem_i ? '0 : {1'b1, {(W-1){1'b0}}}) : '0;
            end
            DIV_CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[W-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DIV_DONE;
                    data_d  = remsel_q ? (rsign_q ? -step_rem[W-1:0] : step_rem[W-1:0])
                                       : (qsign_q ? -quo_d : quo_d);
                end
            end
            default: state_d = DIV_IDLE;
        endcase
        if (kill_i) begin
            state_d = DIV_IDLE;
            data_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            data_q   <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            remsel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            data_q   <= data_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            remsel_q <= remsel_d;
        end
    end

    assign busy_o  = state_q != DIV_IDLE;
    assign valid_o = state_q == DIV_DONE;
    assign data_o  = data_q;
endmodule

// File: tb/tb_pa_core_exu_div.sv
// tb_pa_core_exu_div: directed checks of the divider; cycle n is sampled on the
// falling edge after rising edge n-1, with the accept edge as edge 0.
module tb_pa_core_exu_div;
    logic        clk = 1'b0;
    logic        rst_n_i, start_i, kill_i, sign_i, rem_i;
    logic [31:0] data1_i, data2_i;
    logic        busy_o, valid_o;
    logic [31:0] data_o;
    int          errors = 0;
    int          checks = 0;

    pa_core_exu_div dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .kill_i  (kill_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .sign_i  (sign_i),
        .rem_i   (rem_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .data_o  (data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic r, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        data1_i = a; data2_i = b; sign_i = s; rem_i = r; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        data1_i = 32'hDEAD_BEEF; data2_i = 32'h1; sign_i = ~s; rem_i = ~r;
        lat = 1;
        while (!valid_o && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, data_o, exp);
        @(negedge clk);
        chk({tag, "_vlow"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_dzero"}, data_o, 32'd0);
    endtask

    function automatic logic [31:0] hold_a(input int t);
        return 32'(1000 + 7 * t);
    endfunction

    function automatic logic [31:0] hold_b(input int t);
        return 32'(3 + t);
    endfunction

    initial begin
        int lat;
        int vcnt;
        logic        exp_v, r;
        logic [31:0] a, b;
        rst_n_i = 1'b0; start_i = 1'b0; kill_i = 1'b0; sign_i = 1'b0; rem_i = 1'b0;
        data1_i = '0; data2_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        rst_n_i = 1'b1;

        op("u100d7_q", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 33);
        op("u100d7_r", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 33);
        op("sm7d2_q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 33);
        op("sm7d2_r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 33);
        op("s100dm7_q", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'hFFFF_FFF2, 33);
        op("s100dm7_r", 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'd2, 33);
        op("umax_d1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 33);
        op("umax_r16", 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, 32'h0000_000F, 33);
        op("u8000_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 33);
        op("u8000_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 33);
        op("dz_q", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1);
        op("dz_r", 32'h1234_5678, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 1);
        op("ovf_q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1);
        op("ovf_r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 1);

        // Kill at edge 10, then a fresh 9/3 accepted at edge 12.
        @(negedge clk);
        data1_i = 32'd1000; data2_i = 32'd3; sign_i = 1'b0; rem_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        chk("kill_busy_before", {31'd0, busy_o}, 32'd1);
        kill_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        start_i = 1'b0;
        chk("kill_busy_after", {31'd0, busy_o}, 32'd0);
        chk("kill_valid_after", {31'd0, valid_o}, 32'd0);
        @(negedge clk);
        data1_i = 32'd9; data2_i = 32'd3; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("kill_next_lat", 32'(lat), 32'd33);
        chk("kill_next_data", data_o, 32'd3);
        @(negedge clk);

        // start_i held high with operands changing every cycle.
        @(negedge clk);
        data1_i = hold_a(0); data2_i = hold_b(0); rem_i = 1'b0; start_i = 1'b1;
        for (int t = 0; t <= 100; t++) begin
            @(negedge clk);
            exp_v = (t % 34) == 32;
            chk($sformatf("hold_valid_%0d", t), {31'd0, valid_o}, {31'd0, exp_v});
            if (exp_v) begin
                a = hold_a(t - 32);
                b = hold_b(t - 32);
                r = ((t - 32) % 4) == 2;
                chk($sformatf("hold_data_%0d", t), data_o, r ? a % b : a / b);
            end
            data1_i = hold_a(t + 1); data2_i = hold_b(t + 1); rem_i = ((t + 1) % 4) == 2;
        end
        start_i = 1'b0;
        repeat (40) @(negedge clk);

        // Reset at edge 20 overrides simultaneous kill and start.
        @(negedge clk);
        data1_i = 32'd1000; data2_i = 32'd3; rem_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (19) @(negedge clk);
        rst_n_i = 1'b0; start_i = 1'b1; kill_i = 1'b1;
        @(negedge clk);
        chk("mrst_busy", {31'd0, busy_o}, 32'd0);
        chk("mrst_valid", {31'd0, valid_o}, 32'd0);
        chk("mrst_data", data_o, 32'd0);
        rst_n_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) vcnt++;
        end
        chk("mrst_no_valid", 32'(vcnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
